// File: rtl/random_dispatcher.sv
// Shares one latch-on-rise random generator between NUM_REQ requesters.
// Requests are arbitrated round-robin; out-of-range draws are redrawn, then clamped.
module random_dispatcher #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned SIZE_BITS = 8,
    parameter int unsigned LO_VAL    = 0,
    parameter int unsigned HI_VAL    = 255,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req,
    output logic                 rng_rise,
    input  logic [SIZE_BITS-1:0] rng_dout,
    output logic [NUM_REQ-1:0]   grant_valid,
    output logic [SIZE_BITS-1:0] grant_value,
    output logic                 busy,
    output logic                 retry_err
);

    localparam int unsigned          PtrW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [SIZE_BITS-1:0] LoV      = SIZE_BITS'(LO_VAL);
    localparam logic [SIZE_BITS-1:0] HiV      = SIZE_BITS'(HI_VAL);
    localparam logic [3:0]           MaxRetry = 4'(MAX_RETRY);
    localparam logic [PtrW-1:0]      LastPtr  = PtrW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFire,
        StCapture
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_REQ-1:0]     pending_q, pending_d;
    logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]        winner_q, winner_d;
    logic [3:0]             retry_cnt_q, retry_cnt_d;
    logic                   rise_q, rise_d;
    logic [NUM_REQ-1:0]     grant_valid_q, grant_valid_d;
    logic [SIZE_BITS-1:0]   grant_value_q, grant_value_d;
    logic                   busy_q, busy_d;
    logic                   retry_err_q, retry_err_d;

    logic [NUM_REQ-1:0]     served;
    logic [NUM_REQ-1:0]     winner_oh;
    logic                   found;
    logic [PtrW-1:0]        winner;
    logic [PtrW-1:0]        cand;
    logic [SIZE_BITS:0]     lo_diff;
    logic [SIZE_BITS:0]     hi_diff;
    logic                   below;
    logic                   above;

    // Round-robin scan starting just after the last winner.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        cand   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = PtrW'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && pending_q[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Borrow bits give unsigned range tests that stay well-formed when LO_VAL is 0.
    always_comb begin
        lo_diff = {1'b0, rng_dout} - {1'b0, LoV};
        hi_diff = {1'b0, HiV} - {1'b0, rng_dout};
        below   = lo_diff[SIZE_BITS];
        above   = hi_diff[SIZE_BITS];
    end

    assign winner_oh = NUM_REQ'(1) << winner_q;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        winner_d      = winner_q;
        retry_cnt_d   = retry_cnt_q;
        rise_d        = 1'b0;
        grant_valid_d = '0;
        grant_value_d = grant_value_q;
        busy_d        = busy_q;
        retry_err_d   = 1'b0;
        served        = '0;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (enable && found) begin
                    winner_d    = winner;
                    rr_ptr_d    = winner;
                    retry_cnt_d = '0;
                    rise_d      = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = StFire;
                end
            end
            StFire: begin
                busy_d  = 1'b1;
                state_d = StCapture;
            end
            StCapture: begin
                if (!below && !above) begin
                    grant_valid_d = winner_oh;
                    grant_value_d = rng_dout;
                    served        = winner_oh;
                    busy_d        = 1'b0;
                    state_d       = StIdle;
                end else if (retry_cnt_q < MaxRetry) begin
                    // rise was low this cycle, so the generator sees a fresh edge.
                    retry_cnt_d = retry_cnt_q + 4'd1;
                    rise_d      = 1'b1;
                    state_d     = StFire;
                end else begin
                    grant_valid_d = winner_oh;
                    grant_value_d = below ? LoV : HiV;
                    retry_err_d   = 1'b1;
                    served        = winner_oh;
                    busy_d        = 1'b0;
                    state_d       = StIdle;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase

        // A request arriving while its owner is served survives as a new request.
        pending_d = (pending_q & ~served) | req;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= StIdle;
            pending_q     <= '0;
            rr_ptr_q      <= LastPtr;
            winner_q      <= '0;
            retry_cnt_q   <= '0;
            rise_q        <= 1'b0;
            grant_valid_q <= '0;
            grant_value_q <= '0;
            busy_q        <= 1'b0;
            retry_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            rr_ptr_q      <= rr_ptr_d;
            winner_q      <= winner_d;
            retry_cnt_q   <= retry_cnt_d;
            rise_q        <= rise_d;
            grant_valid_q <= grant_valid_d;
            grant_value_q <= grant_value_d;
            busy_q        <= busy_d;
            retry_err_q   <= retry_err_d;
        end
    end

    assign rng_rise    = rise_q;
    assign grant_valid = grant_valid_q;
    assign grant_value = grant_value_q;
    assign busy        = busy_q;
    assign retry_err   = retry_err_q;

    a_rise_single: assert property (@(posedge clk) disable iff (!resetN)
        rise_q |=> !rise_q);
    a_grant_onehot: assert property (@(posedge clk) disable iff (!resetN)
        $onehot0(grant_valid_q));
    a_busy_state: assert property (@(posedge clk) disable iff (!resetN)
        busy_q == (state_q != StIdle));

endmodule

// File: tb/tb_random_dispatcher.sv
// Bench for random_dispatcher: two instances (full range, narrow range) checked every
// cycle against a transaction-level reference model and an emulated generator.
module tb_random_dispatcher;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] req   [2];
    logic       rise  [2];
    logic [7:0] dout  [2];
    logic [3:0] gv    [2];
    logic [7:0] gval  [2];
    logic       busy  [2];
    logic       err   [2];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    random_dispatcher #(
        .NUM_REQ(4), .SIZE_BITS(8), .LO_VAL(0), .HI_VAL(255), .MAX_RETRY(3)
    ) u_dut_a (
        .clk(clk), .resetN(resetN), .enable(enable), .req(req[0]),
        .rng_rise(rise[0]), .rng_dout(dout[0]), .grant_valid(gv[0]),
        .grant_value(gval[0]), .busy(busy[0]), .retry_err(err[0])
    );

    random_dispatcher #(
        .NUM_REQ(4), .SIZE_BITS(8), .LO_VAL(200), .HI_VAL(210), .MAX_RETRY(3)
    ) u_dut_b (
        .clk(clk), .resetN(resetN), .enable(enable), .req(req[1]),
        .rng_rise(rise[1]), .rng_dout(dout[1]), .grant_valid(gv[1]),
        .grant_value(gval[1]), .busy(busy[1]), .retry_err(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Generator emulation: instance a latches a free-running counter, b replays a queue.
    logic [7:0] gen_cnt;
    bit         gen_prev [2];
    logic [7:0] q_b [$];

    always @(posedge clk) begin
        gen_cnt     <= gen_cnt + 8'd1;
        gen_prev[0] <= rise[0];
        gen_prev[1] <= rise[1];
        if (rise[0] && !gen_prev[0]) dout[0] <= gen_cnt;
        if (rise[1] && !gen_prev[1]) begin
            if (q_b.size() > 0) dout[1] <= q_b.pop_front();
            else dout[1] <= 8'($urandom_range(0, 255));
        end
    end

    // Reference model state, one slot per instance.
    int         m_lo  [2] = '{0, 200};
    int         m_hi  [2] = '{255, 210};
    int         m_max = 3;
    bit [3:0]   m_pend [2];
    int         m_ptr  [2];
    bit         m_rst  [2] = '{1'b1, 1'b1};
    bit         exp_rise [2];
    bit [3:0]   exp_gv   [2];
    bit [7:0]   exp_val  [2];
    bit         exp_busy [2];
    bit         exp_err  [2];

    task automatic model_reset(input int k);
        m_rst[k]    = 1'b1;
        m_pend[k]   = '0;
        m_ptr[k]    = 3;
        exp_rise[k] = 1'b0;
        exp_gv[k]   = '0;
        exp_val[k]  = '0;
        exp_busy[k] = 1'b0;
        exp_err[k]  = 1'b0;
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
    end

    always @(negedge resetN) begin
        model_reset(0);
        model_reset(1);
    end

    function automatic int pick(input int k);
        for (int i = 1; i <= 4; i++) begin
            int j;
            j = (m_ptr[k] + i) % 4;
            if (m_pend[k][j]) return j;
        end
        return -1;
    endfunction

    task automatic edge_k(input int k, output bit ok, output logic [3:0] r, output bit e);
        @(posedge clk);
        ok = !m_rst[k];
        r  = req[k];
        e  = enable;
    endtask

    // One draw is: decide at an idle edge, fire, capture, then deliver, redraw or clamp.
    task automatic model_run(input int k);
        bit         ok;
        bit         en_s;
        bit         go;
        bit         done;
        logic [3:0] r;
        int         w;
        int         tries;
        int         v;
        forever begin
            if (m_rst[k]) begin
                wait (resetN === 1'b1);
                m_rst[k] = 1'b0;
            end
            edge_k(k, ok, r, en_s);
            if (!ok) continue;
            exp_gv[k]  = '0;
            exp_err[k] = 1'b0;
            go = en_s && (m_pend[k] != 0);
            w  = go ? pick(k) : -1;
            m_pend[k] |= r;
            if (!go) continue;
            m_ptr[k]    = w;
            exp_busy[k] = 1'b1;
            tries       = 0;
            done        = 1'b0;
            while (!done) begin
                exp_rise[k] = 1'b1;
                edge_k(k, ok, r, en_s);
                if (!ok) break;
                m_pend[k] |= r;
                exp_rise[k] = 1'b0;
                edge_k(k, ok, r, en_s);
                if (!ok) break;
                v = int'(dout[k]);
                if (v >= m_lo[k] && v <= m_hi[k]) begin
                    done = 1'b1;
                end else if (tries < m_max) begin
                    tries++;
                    m_pend[k] |= r;
                end else begin
                    v = (v < m_lo[k]) ? m_lo[k] : m_hi[k];
                    exp_err[k] = 1'b1;
                    done = 1'b1;
                end
                if (done) begin
                    m_pend[k][w] = 1'b0;
                    m_pend[k]   |= r;
                    exp_gv[k]    = 4'b0001 << w;
                    exp_val[k]   = 8'(v);
                    exp_busy[k]  = 1'b0;
                end
            end
        end
    endtask

    initial model_run(0);
    initial model_run(1);

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                string p;
                p = (k == 0) ? "a" : "b";
                check({p, ".rise"},  32'(rise[k]), 32'(exp_rise[k]));
                check({p, ".gv"},    32'(gv[k]),   32'(exp_gv[k]));
                check({p, ".gval"},  32'(gval[k]), 32'(exp_val[k]));
                check({p, ".busy"},  32'(busy[k]), 32'(exp_busy[k]));
                check({p, ".err"},   32'(err[k]),  32'(exp_err[k]));
            end
        end
    end

    task automatic pulse(input int k, input logic [3:0] v);
        @(negedge clk);
        req[k] = v;
        @(negedge clk);
        req[k] = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for a FIRE cycle on instance k, observed at a negedge.
    task automatic wait_rise(input int k);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rise[k]) seen = 1'b1;
        end
        check("wait_rise", 32'(seen), 32'd1);
    endtask

    initial begin
        gen_cnt = 8'($urandom);
        req[0]  = '0;
        req[1]  = '0;
        dout[0] = '0;
        dout[1] = '0;
        idle(1);
        chk_on = 1'b1;
        idle(2);
        resetN = 1'b1;
        enable = 1'b1;

        // Single request, then a full round-robin sweep and a wrap-around pair.
        pulse(0, 4'b0001);
        idle(8);
        pulse(0, 4'b1111);
        idle(14);
        pulse(0, 4'b1001);
        idle(8);

        // Requester 2 re-requests in the cycle its draw is captured.
        pulse(0, 4'b0100);
        idle(1);
        pulse(0, 4'b0100);
        idle(10);

        // Redraw to an in-range value, then retry exhaustion with clamping.
        q_b.push_back(8'd5);
        q_b.push_back(8'd250);
        q_b.push_back(8'd205);
        pulse(1, 4'b0010);
        idle(12);
        repeat (4) q_b.push_back(8'd5);
        pulse(1, 4'b1000);
        idle(14);
        q_b.push_back(8'd230);
        q_b.push_back(8'd230);
        q_b.push_back(8'd230);
        q_b.push_back(8'd240);
        pulse(1, 4'b0001);
        idle(14);

        // Drop enable during FIRE: draw completes, nothing new starts until re-enabled.
        pulse(0, 4'b0011);
        wait_rise(0);
        enable = 1'b0;
        idle(10);
        enable = 1'b1;
        idle(8);

        // Reset in CAPTURE: outputs clear at once and pending requests are dropped.
        pulse(0, 4'b1010);
        wait_rise(0);
        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        check("rst.rise", 32'(rise[0]), 32'd0);
        check("rst.busy", 32'(busy[0]), 32'd0);
        check("rst.gv",   32'(gv[0]),   32'd0);
        check("rst.gval", 32'(gval[0]), 32'd0);
        check("rst.err",  32'(err[0]),  32'd0);
        idle(2);
        resetN = 1'b1;
        idle(10);

        // Randomized traffic on both instances.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            req[0] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            req[1] = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            enable = ($urandom_range(0, 9) != 0);
            if (q_b.size() < 4) q_b.push_back(8'($urandom_range(190, 225)));
        end
        @(negedge clk);
        req[0] = '0;
        req[1] = '0;
        enable = 1'b1;
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
